prog_clk_divider: RTL

Multi-channel, runtime-programmable clock/tick divider that supersedes the fixed-parameter divider. Each of NCH channels owns a counter, a divisor, and a mode:
- toggle: square wave with a period of 2*D input cycles.
- pulse: one-cycle strobe every D input cycles.

Divisors are written through a simple config port into shadow registers and applied glitch-free at the channel's next terminal count. The block sits next to the top-level clock and feeds display refresh, debouncers and timers.

---
 rtl/prog_clk_divider_pkg.sv | 18 +
 rtl/clk_div_channel.sv | 100 ++++++++++
 rtl/prog_clk_divider.sv | 44 ++++
 3 files changed

// File: rtl/prog_clk_divider_pkg.sv
// Shared definitions for the programmable clock/tick divider:
// mode encodings and the width helper for the channel-select bus.
package prog_clk_divider_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Bits needed to address n channels; never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active and shadow divisor/mode registers,
// terminal-count detection and the registered divided output.
module clk_div_channel
    import prog_clk_divider_pkg::*;
#(
    parameter int W        = 32,
    parameter int DEF_DIV  = 4,
    parameter bit DEF_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] div,
    input  logic         mode,
    output logic         clk_out,
    output logic         busy
);

    localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] sh_div_q, sh_div_d;
    logic         mode_q, mode_d;
    logic         sh_mode_q, sh_mode_d;
    logic         busy_q, busy_d;
    logic         out_q, out_d;

    logic halted, tc, apply, is_pulse;

    // The D-1 compare is only meaningful when D is non-zero.
    assign halted   = (div_q == '0);
    assign tc       = en && !halted && (cnt_q == div_q - ONE);
    assign apply    = busy_q && (tc || halted || !en);
    assign is_pulse = (mode_q == MODE_PULSE);

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        mode_d    = mode_q;
        sh_div_d  = sh_div_q;
        sh_mode_d = sh_mode_q;
        busy_d    = busy_q;
        out_d     = out_q;

        if (!en) begin
            out_d = is_pulse ? 1'b0 : out_q;
        end else if (halted) begin
            out_d = 1'b0;
            cnt_d = '0;
        end else if (tc) begin
            out_d = is_pulse ? 1'b1 : ~out_q;
            cnt_d = '0;
        end else begin
            out_d = is_pulse ? 1'b0 : out_q;
            cnt_d = cnt_q + ONE;
        end

        // The pending shadow is applied before a same-cycle write refills it.
        if (apply) begin
            div_d  = sh_div_q;
            mode_d = sh_mode_q;
            cnt_d  = '0;
            busy_d = 1'b0;
            if (sh_mode_q != mode_q) out_d = 1'b0;
        end

        if (wr) begin
            sh_div_d  = div;
            sh_mode_d = mode;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= DEF_DIV_W;
            mode_q    <= DEF_MODE;
            sh_div_q  <= DEF_DIV_W;
            sh_mode_q <= DEF_MODE;
            busy_q    <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            sh_div_q  <= sh_div_d;
            sh_mode_q <= sh_mode_d;
            busy_q    <= busy_d;
            out_q     <= out_d;
        end
    end

    assign clk_out = out_q;
    assign busy    = busy_q;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel runtime-programmable clock/tick divider: decodes the config
// port to a per-channel write strobe and instantiates one divider per channel.
module prog_clk_divider
    import prog_clk_divider_pkg::*;
#(
    parameter int  NCH      = 4,
    parameter int  W        = 32,
    parameter int  DEF_DIV  = 4,
    parameter bit  DEF_MODE = 1'b0,
    localparam int CHW      = clog2_min1(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_div,
    input  logic           cfg_mode,
    input  logic [NCH-1:0] ch_en,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] busy
);

    // Addresses at or beyond NCH match no instance and are dropped.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == CHW'(gi));

        clk_div_channel #(
            .W        (W),
            .DEF_DIV  (DEF_DIV),
            .DEF_MODE (DEF_MODE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[gi]),
            .wr      (wr),
            .div     (cfg_div),
            .mode    (cfg_mode),
            .clk_out (clk_out[gi]),
            .busy    (busy[gi])
        );
    end

endmodule
